// File: rtl/sa_psum_accumulator_if.sv
// Handshake/bus bundle between the systolic array, the partial-sum
// accumulator and writeback.
//   psum side : i_psum_valid / o_psum_ready, i_psum, i_first_tile, i_last_tile
//   result side: o_acc_valid / i_acc_ready, o_acc, o_acc_last
//   control   : i_clear (synchronous abort)
// slave  : accumulator view (drives the o_* signals)
// master : producer/consumer view (drives the i_* signals)
interface sa_psum_accumulator_if #(
  parameter int NUM_COLS      = 4,
  parameter int ADD_DATAWIDTH = 8,
  parameter int ACC_DATAWIDTH = 16
);
  logic                              i_clear;
  logic                              i_psum_valid;
  logic                              o_psum_ready;
  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum;
  logic                              i_first_tile;
  logic                              i_last_tile;
  logic                              o_acc_valid;
  logic                              i_acc_ready;
  logic [NUM_COLS*ACC_DATAWIDTH-1:0] o_acc;
  logic                              o_acc_last;

  modport slave (
    input  i_clear, i_psum_valid, i_psum, i_first_tile, i_last_tile, i_acc_ready,
    output o_psum_ready, o_acc_valid, o_acc, o_acc_last
  );

  modport master (
    output i_clear, i_psum_valid, i_psum, i_first_tile, i_last_tile, i_acc_ready,
    input  o_psum_ready, o_acc_valid, o_acc, o_acc_last
  );
endinterface

// File: rtl/sa_psum_accumulator.sv
// Partial-sum accumulator below the systolic array.
// Accumulates per-column psum rows across K tiles into a DEPTH x NUM_COLS
// buffer with signed saturation, then drains the buffer row by row.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : sa_psum_accumulator_if.slave (psum input, result output, clear)
module sa_psum_accumulator #(
  parameter int NUM_COLS      = 4,
  parameter int ADD_DATAWIDTH = 8,
  parameter int ACC_DATAWIDTH = 16,
  parameter int DEPTH         = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sa_psum_accumulator_if.slave  bus
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_ROW = PTR_W'(DEPTH - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic                     first_q, first_d;
  logic                     last_q, last_d;
  logic [ACC_DATAWIDTH-1:0] mem_q [DEPTH][NUM_COLS];
  logic [ACC_DATAWIDTH-1:0] row_d [NUM_COLS];
  logic                     wr_en;

  logic                     beat;
  logic                     first_eff;
  logic                     last_eff;
  logic [NUM_COLS*ACC_DATAWIDTH-1:0] acc_o;

  // Tile flags are only sampled on the row-0 beat; later rows reuse the
  // latched copies so upstream may change them mid-tile.
  assign beat      = bus.i_psum_valid && (state_q == ST_ACCUM);
  assign first_eff = (wr_ptr_q == '0) ? bus.i_first_tile : first_q;
  assign last_eff  = (wr_ptr_q == '0) ? bus.i_last_tile  : last_q;

  // Saturating add per lane. The sum is formed one bit wider than the
  // accumulator; a mismatch of the top two bits flags overflow and the
  // top bit gives its direction.
  always_comb begin
    logic signed [ADD_DATAWIDTH-1:0] psum_s;
    logic signed [ACC_DATAWIDTH-1:0] psum_x;
    logic signed [ACC_DATAWIDTH:0]   sum;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      psum_s = bus.i_psum[c*ADD_DATAWIDTH +: ADD_DATAWIDTH];
      psum_x = ACC_DATAWIDTH'(psum_s);
      sum    = {mem_q[wr_ptr_q][c][ACC_DATAWIDTH-1], mem_q[wr_ptr_q][c]}
             + {psum_x[ACC_DATAWIDTH-1], psum_x};
      if (first_eff) begin
        row_d[c] = psum_x;
      end else if (sum[ACC_DATAWIDTH] != sum[ACC_DATAWIDTH-1]) begin
        row_d[c] = sum[ACC_DATAWIDTH] ? {1'b1, {(ACC_DATAWIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_DATAWIDTH-1){1'b1}}};
      end else begin
        row_d[c] = sum[ACC_DATAWIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    first_d  = first_q;
    last_d   = last_q;
    wr_en    = 1'b0;
    if (bus.i_clear) begin
      // Abort: pointers and FSM restart, buffer contents survive.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            wr_en    = 1'b1;
            first_d  = first_eff;
            last_d   = last_eff;
            wr_ptr_d = (wr_ptr_q == LAST_ROW) ? '0 : wr_ptr_q + 1'b1;
            if ((wr_ptr_q == LAST_ROW) && last_eff) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.i_acc_ready) begin
            if (rd_ptr_q == LAST_ROW) begin
              rd_ptr_d = '0;
              state_d  = ST_ACCUM;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_ACCUM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      if (wr_en) begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
          mem_q[wr_ptr_q][c] <= row_d[c];
        end
      end
    end
  end

  always_comb begin
    acc_o = '0;
    if (state_q == ST_DRAIN) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        acc_o[c*ACC_DATAWIDTH +: ACC_DATAWIDTH] = mem_q[rd_ptr_q][c];
      end
    end
  end

  assign bus.o_psum_ready = (state_q == ST_ACCUM);
  assign bus.o_acc_valid  = (state_q == ST_DRAIN);
  assign bus.o_acc        = acc_o;
  assign bus.o_acc_last   = (state_q == ST_DRAIN) && (rd_ptr_q == LAST_ROW);

endmodule

// File: tb/tb_sa_psum_accumulator.sv
module tb_sa_psum_accumulator;
  localparam int NC = 4;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int D  = 4;
  localparam int ACC_MAX = (1 << (CW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (CW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_psum_accumulator_if #(.NUM_COLS(NC), .ADD_DATAWIDTH(AW), .ACC_DATAWIDTH(CW)) bus ();

  sa_psum_accumulator #(
    .NUM_COLS(NC), .ADD_DATAWIDTH(AW), .ACC_DATAWIDTH(CW), .DEPTH(D)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int model [D][NC];   // expected buffer contents
  int tp    [D][NC];   // current tile psums

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input longint v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return int'(v);
  endfunction

  function automatic logic [NC*AW-1:0] pack_row(input int r);
    logic [NC*AW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*AW +: AW] = AW'(tp[r][c]);
    return v;
  endfunction

  function automatic logic [NC*CW-1:0] exp_row(input int r);
    logic [NC*CW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*CW +: CW] = CW'(model[r][c]);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tile(input int lo, input int hi);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < NC; c++) tp[r][c] = lo + int'($urandom_range(0, hi - lo));
  endtask

  // Offer rows [0, nrows) of tp; flags on rows > 0 are random garbage
  // because only the row-0 values are meaningful.
  task automatic send_rows(input bit first, input bit last, input int nrows);
    int n;
    for (int r = 0; r < nrows; r++) begin
      bus.i_psum_valid = 1'b1;
      bus.i_psum       = pack_row(r);
      bus.i_first_tile = (r == 0) ? first : 1'($urandom_range(0, 1));
      bus.i_last_tile  = (r == 0) ? last  : 1'($urandom_range(0, 1));
      n = 0;
      while (!bus.o_psum_ready && n < 50) begin
        cyc();
        n++;
      end
      if (n >= 50) chk("psum_ready_timeout", 64'(bus.o_psum_ready), 64'd1);
      cyc();
      for (int c = 0; c < NC; c++)
        model[r][c] = first ? tp[r][c] : clamp(longint'(model[r][c]) + tp[r][c]);
    end
    bus.i_psum_valid = 1'b0;
    bus.i_first_tile = 1'b0;
    bus.i_last_tile  = 1'b0;
  endtask

  task automatic drain(input string tag, input bit backpressure);
    int stall;
    for (int r = 0; r < D; r++) begin
      stall = backpressure ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < stall; s++) begin
        bus.i_acc_ready = 1'b0;
        chk({tag, "_stall_valid"}, 64'(bus.o_acc_valid), 64'd1);
        chk({tag, "_stall_data"}, 64'(bus.o_acc), 64'(exp_row(r)));
        chk({tag, "_stall_pready"}, 64'(bus.o_psum_ready), 64'd0);
        cyc();
      end
      bus.i_acc_ready = 1'b1;
      chk({tag, "_valid"}, 64'(bus.o_acc_valid), 64'd1);
      chk({tag, "_data"}, 64'(bus.o_acc), 64'(exp_row(r)));
      chk({tag, "_last"}, 64'(bus.o_acc_last), 64'(r == D - 1));
      chk({tag, "_pready"}, 64'(bus.o_psum_ready), 64'd0);
      cyc();
    end
    bus.i_acc_ready = 1'b0;
    chk({tag, "_end_valid"}, 64'(bus.o_acc_valid), 64'd0);
    chk({tag, "_end_pready"}, 64'(bus.o_psum_ready), 64'd1);
    chk({tag, "_end_acc"}, 64'(bus.o_acc), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_clear = 1'b0;
    bus.i_psum_valid = 1'b0;
    bus.i_psum = '0;
    bus.i_first_tile = 1'b0;
    bus.i_last_tile = 1'b0;
    bus.i_acc_ready = 1'b0;
    for (int r = 0; r < D; r++) for (int c = 0; c < NC; c++) model[r][c] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    chk("rst_pready", 64'(bus.o_psum_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_acc_valid), 64'd0);
    chk("rst_acc", 64'(bus.o_acc), 64'd0);
    chk("rst_last", 64'(bus.o_acc_last), 64'd0);

    // 1: single-tile pass, lane0 = 1..4
    for (int r = 0; r < D; r++) for (int c = 0; c < NC; c++) tp[r][c] = (c == 0) ? r + 1 : 0;
    send_rows(1'b1, 1'b1, D);
    drain("t1", 1'b0);

    // 2: tile A lane1=10 then tile B lane1=-3 -> 7
    rand_tile(-128, 127);
    for (int r = 0; r < D; r++) tp[r][1] = 10;
    send_rows(1'b1, 1'b0, D);
    chk("t2_no_drain", 64'(bus.o_acc_valid), 64'd0);
    rand_tile(-128, 127);
    for (int r = 0; r < D; r++) tp[r][1] = -3;
    send_rows(1'b0, 1'b1, D);
    chk("t2_lane1_row0", 64'(bus.o_acc[CW +: CW]), 64'd7);
    drain("t2", 1'b0);

    // 3: saturation then clean reload
    for (int r = 0; r < D; r++) for (int c = 0; c < NC; c++) tp[r][c] = 127;
    for (int t = 0; t < 300; t++) send_rows(t == 0, t == 299, D);
    chk("t3_sat_max", 64'(bus.o_acc[0 +: CW]), 64'h7fff);
    drain("t3_sat", 1'b0);
    for (int r = 0; r < D; r++) for (int c = 0; c < NC; c++) tp[r][c] = -128;
    send_rows(1'b1, 1'b1, D);
    chk("t3_reload", 64'(bus.o_acc[0 +: CW]), 64'hff80);
    drain("t3_reload", 1'b0);

    // 4: back-pressure with an upstream row held during drain
    rand_tile(-128, 127);
    send_rows(1'b1, 1'b1, D);
    rand_tile(-128, 127);
    bus.i_psum_valid = 1'b1;
    bus.i_psum       = pack_row(0);
    bus.i_first_tile = 1'b1;
    bus.i_last_tile  = 1'b1;
    drain("t4", 1'b1);
    send_rows(1'b1, 1'b1, D);
    drain("t4_next", 1'b1);

    // 5: clear at wr_ptr=2 of a last tile
    rand_tile(-128, 127);
    send_rows(1'b1, 1'b1, 2);
    bus.i_psum_valid = 1'b1;
    bus.i_psum       = pack_row(2);
    bus.i_clear      = 1'b1;
    cyc();
    bus.i_clear      = 1'b0;
    bus.i_psum_valid = 1'b0;
    chk("t5_pready", 64'(bus.o_psum_ready), 64'd1);
    chk("t5_valid", 64'(bus.o_acc_valid), 64'd0);
    cyc();
    chk("t5_valid2", 64'(bus.o_acc_valid), 64'd0);
    rand_tile(-128, 127);
    send_rows(1'b1, 1'b1, D);
    drain("t5", 1'b0);

    // 6: async reset mid-drain
    rand_tile(-128, 127);
    send_rows(1'b1, 1'b1, D);
    bus.i_acc_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      chk("t6_pre_data", 64'(bus.o_acc), 64'(exp_row(r)));
      cyc();
    end
    bus.i_acc_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 64'(bus.o_acc_valid), 64'd0);
    chk("t6_rst_acc", 64'(bus.o_acc), 64'd0);
    chk("t6_rst_pready", 64'(bus.o_psum_ready), 64'd1);
    chk("t6_rst_last", 64'(bus.o_acc_last), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int r = 0; r < D; r++) for (int c = 0; c < NC; c++) model[r][c] = 0;
    cyc();
    rand_tile(-128, 127);
    send_rows(1'b0, 1'b1, D);
    drain("t6_after", 1'b0);

    // Random multi-tile passes with random back-pressure
    for (int p = 0; p < 8; p++) begin
      int nt;
      nt = int'($urandom_range(1, 3));
      for (int t = 0; t < nt; t++) begin
        rand_tile(-128, 127);
        send_rows((t == 0) && (p % 3 != 2), t == nt - 1, D);
      end
      drain("rnd", 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
